// File: rtl/display_mux_scheduler_if.sv
// Digit bus between the switch inputs, the display scheduler and the shared
// seven-segment decoder / anode drivers.
// master: the scheduler; slave: the surrounding lab top level.
interface display_mux_scheduler_if;
   logic [3:0] switch1;
   logic [3:0] switch2;
   logic [3:0] seg_digit;
   logic [1:0] anode;
   logic       digit_sel;
   logic       frame_tick;

   modport master (
      input  switch1,
      input  switch2,
      output seg_digit,
      output anode,
      output digit_sel,
      output frame_tick
   );

   modport slave (
      output switch1,
      output switch2,
      input  seg_digit,
      input  anode,
      input  digit_sel,
      input  frame_tick
   );
endinterface

// File: rtl/display_mux_scheduler.sv
// Time-multiplexes switch1/switch2 onto one shared seven-segment decoder and
// drives the matching active-low anode enables.
// Optional dead time between digits: define DISPLAY_BLANK_EN to build the
// BLANK0/BLANK1 states; otherwise SHOW0 and SHOW1 alternate directly.
module display_mux_scheduler #(
   parameter int unsigned REFRESH_DIV  = 4,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   display_mux_scheduler_if.master bus
);

   localparam int unsigned MAX_N = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int unsigned CNT_W = $clog2(MAX_N);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
`ifdef DISPLAY_BLANK_EN
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_SHOW0  = 3'd1,
      ST_SHOW1  = 3'd2
`ifdef DISPLAY_BLANK_EN
      ,
      ST_BLANK0 = 3'd3,
      ST_BLANK1 = 3'd4
`endif
   } state_e;

   state_e           r_state;
   state_e           w_state_n;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_n;
   logic [3:0]       r_digit;
   logic [3:0]       w_digit_n;
   logic [1:0]       r_anode;
   logic [1:0]       w_anode_n;
   logic             r_sel;
   logic             w_sel_n;
   logic             r_tick;
   logic             w_tick_n;

   // State, phase counter, digit latch and registered Moore outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
         r_digit <= 4'h0;
         r_anode <= 2'b11;
         r_sel   <= 1'b0;
         r_tick  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_digit <= w_digit_n;
         r_anode <= w_anode_n;
         r_sel   <= w_sel_n;
         r_tick  <= w_tick_n;
      end
   end

   // Next state, digit load on show entry, and output decode of the next state
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt + CNT_W'(1);
      w_digit_n = r_digit;
      w_anode_n = 2'b11;
      w_sel_n   = r_sel;
      w_tick_n  = 1'b0;

      case (r_state)
         ST_INIT: begin
            w_state_n = ST_SHOW0;
            w_cnt_n   = '0;
         end
         ST_SHOW0: begin
            if (r_cnt == SHOW_LAST) begin
`ifdef DISPLAY_BLANK_EN
               w_state_n = ST_BLANK0;
`else
               w_state_n = ST_SHOW1;
`endif
               w_cnt_n   = '0;
            end
         end
         ST_SHOW1: begin
            if (r_cnt == SHOW_LAST) begin
`ifdef DISPLAY_BLANK_EN
               w_state_n = ST_BLANK1;
`else
               w_state_n = ST_SHOW0;
`endif
               w_cnt_n   = '0;
            end
         end
`ifdef DISPLAY_BLANK_EN
         ST_BLANK0: begin
            if (r_cnt == BLANK_LAST) begin
               w_state_n = ST_SHOW1;
               w_cnt_n   = '0;
            end
         end
         ST_BLANK1: begin
            if (r_cnt == BLANK_LAST) begin
               w_state_n = ST_SHOW0;
               w_cnt_n   = '0;
            end
         end
`endif
         default: begin
            w_state_n = ST_INIT;
            w_cnt_n   = '0;
         end
      endcase

      // Latch the digit on the edge that enters its show phase
      if (w_state_n == ST_SHOW0 && r_state != ST_SHOW0) begin
         w_digit_n = bus.switch1;
         w_tick_n  = (r_state != ST_INIT);
      end else if (w_state_n == ST_SHOW1 && r_state != ST_SHOW1) begin
         w_digit_n = bus.switch2;
      end

      case (w_state_n)
         ST_SHOW0: begin
            w_anode_n = 2'b10;
            w_sel_n   = 1'b0;
         end
         ST_SHOW1: begin
            w_anode_n = 2'b01;
            w_sel_n   = 1'b1;
         end
         default: w_anode_n = 2'b11;
      endcase
   end

   assign bus.seg_digit  = r_digit;
   assign bus.anode      = r_anode;
   assign bus.digit_sel  = r_sel;
   assign bus.frame_tick = r_tick;

endmodule
